// File: rtl/mul_share_arbiter.sv
// Schedules one external 32x32 multiplier between two valid/ready requesters.
// Build option MUL_ARB_FIXED_PRIO_EN: requester 0 always wins ties (round-robin otherwise).
module mul_share_arbiter #(
    parameter int unsigned WAIT_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [63:0] rsp0_p,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [63:0] rsp1_p,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_p,
    output logic        busy
);
    localparam logic [3:0] CntInit = 4'(WAIT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e     state;
    logic       owner;
    logic [3:0] count;
    logic       gnt0;
    logic       gnt1;
    logic       rsp_take;

    assign rsp_take = (state == StResp) && (owner ? rsp1_ready : rsp0_ready);

`ifdef MUL_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt0 = req0_valid;
        gnt1 = req1_valid && !req0_valid;
    end
`else
    logic rr_last;

    // rr_last names the requester served most recently; the other one wins a tie.
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || rr_last);
        gnt1 = req1_valid && (!req0_valid || !rr_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= 1'b1;
        end else if (rsp_take) begin
            rr_last <= owner;
        end
    end
`endif

    // Readies are masked by rst_n so nothing is granted while reset is held.
    always_comb begin
        req0_ready = rst_n && (state == StIdle) && gnt0;
        req1_ready = rst_n && (state == StIdle) && gnt1;
        rsp0_valid = (state == StResp) && !owner;
        rsp1_valid = (state == StResp) && owner;
        busy       = (state != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            mul_a  <= '0;
            mul_b  <= '0;
            owner  <= 1'b0;
            count  <= '0;
            rsp0_p <= '0;
            rsp1_p <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (gnt0 || gnt1) begin
                        mul_a <= gnt0 ? req0_a : req1_a;
                        mul_b <= gnt0 ? req0_b : req1_b;
                        owner <= gnt1;
                        count <= CntInit;
                        state <= StWait;
                    end
                end
                StWait: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        // Per-port product registers double as the result register.
                        if (owner) begin
                            rsp1_p <= mul_p;
                        end else begin
                            rsp0_p <= mul_p;
                        end
                        state <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_take) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Self-checking bench for mul_share_arbiter: vector table, hand sequences, random jobs
// against a product scoreboard. Honours MUL_ARB_FIXED_PRIO_EN for expected tie winners.
module tb_mul_share_arbiter;
    typedef struct {
        bit          v0;
        bit          v1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        bit          port;
        logic [63:0] p;
        int          stall;
    } vec_t;

    typedef struct {
        bit          port;
        logic [63:0] p;
    } exp_t;

`ifdef MUL_ARB_FIXED_PRIO_EN
    localparam bit Fixed = 1'b1;
`else
    localparam bit Fixed = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [63:0] rsp0_p, rsp1_p;
    logic [31:0] mul_a, mul_b;
    logic [63:0] mul_p;
    logic        busy;

    logic        w3_valid, w3_ready, w3_rsp_valid, w3_rsp_ready, w3_busy;
    logic [31:0] w3_a, w3_b, w3_mul_a, w3_mul_b;
    logic [63:0] w3_rsp_p, w3_mul_p, w3_rsp1_p;
    logic        w3_req1_ready, w3_rsp1_valid;

    int   total = 0;
    int   bad = 0;
    int   accepts = 0;
    int   resps = 0;
    bit   model_last = 1'b1;
    exp_t sb[$];

    always #5 clk = ~clk;

    assign mul_p    = 64'(mul_a) * 64'(mul_b);
    assign w3_mul_p = 64'(w3_mul_a) * 64'(w3_mul_b);

    mul_share_arbiter #(.WAIT_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
    );

    mul_share_arbiter #(.WAIT_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(w3_valid), .req0_ready(w3_ready), .req0_a(w3_a), .req0_b(w3_b),
        .req1_valid(1'b0), .req1_ready(w3_req1_ready), .req1_a(32'd0), .req1_b(32'd0),
        .rsp0_valid(w3_rsp_valid), .rsp0_ready(w3_rsp_ready), .rsp0_p(w3_rsp_p),
        .rsp1_valid(w3_rsp1_valid), .rsp1_ready(1'b0), .rsp1_p(w3_rsp1_p),
        .mul_a(w3_mul_a), .mul_b(w3_mul_b), .mul_p(w3_mul_p), .busy(w3_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input bit port, input logic [63:0] p);
        exp_t e;
        resps++;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_extra: response on port %0d got %h want none", port, p);
        end else begin
            e = sb.pop_front();
            check("sb_port", 64'(port), 64'(e.port));
            check("sb_prod", p, e.p);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("exclusive", 64'((req0_ready & req1_ready) | (rsp0_valid & rsp1_valid)), 64'd0);
            if (req0_valid && req0_ready) begin
                e.port = 1'b0;
                e.p = 64'(req0_a) * 64'(req0_b);
                sb.push_back(e);
                accepts++;
            end
            if (req1_valid && req1_ready) begin
                e.port = 1'b1;
                e.p = 64'(req1_a) * 64'(req1_b);
                sb.push_back(e);
                accepts++;
            end
            if (rsp0_valid && rsp0_ready) sb_pop(1'b0, rsp0_p);
            if (rsp1_valid && rsp1_ready) sb_pop(1'b1, rsp1_p);
        end
    end

    // Entered and left at posedge+1 with the DUT idle.
    task automatic do_round(input vec_t v);
        int          n;
        logic [31:0] ea;
        logic [31:0] eb;
        ea = v.port ? v.a1 : v.a0;
        eb = v.port ? v.b1 : v.b0;
        req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 20) begin
            @(posedge clk); #2; n++;
        end
        check("grant_delay", 64'(n), 64'd0);
        if (n == 20) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check("grant0", 64'(req0_ready), 64'(!v.port));
        check("grant1", 64'(req1_ready), 64'(v.port));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("busy_wait", 64'(busy), 64'd1);
        n = 0;
        while (!(rsp0_valid || rsp1_valid) && n < 40) begin
            check("mul_a", 64'(mul_a), 64'(ea));
            check("mul_b", 64'(mul_b), 64'(eb));
            @(posedge clk); #1; n++;
        end
        check("latency", 64'(n), 64'd1);
        if (n == 40) return;
        check("rsp0_valid", 64'(rsp0_valid), 64'(!v.port));
        check("rsp1_valid", 64'(rsp1_valid), 64'(v.port));
        for (int s = 0; s < v.stall; s++) begin
            if (v.port) req0_valid = 1'b1; else req1_valid = 1'b1;
            #1;
            check("stall_ready", 64'(req0_ready | req1_ready), 64'd0);
            @(posedge clk); #1;
            check("stall_valid", 64'(v.port ? rsp1_valid : rsp0_valid), 64'd1);
            check("stall_p", v.port ? rsp1_p : rsp0_p, v.p);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        // Non-owner ready is also raised; it must be ignored.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        check("rsp_p", v.port ? rsp1_p : rsp0_p, v.p);
        @(posedge clk); #1;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("busy_idle", 64'(busy), 64'd0);
        check("rsp_drop", 64'(rsp0_valid | rsp1_valid), 64'd0);
        check("p_hold", v.port ? rsp1_p : rsp0_p, v.p);
        model_last = v.port;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    tbl[$];
        vec_t    v;
        int      n;
        int      sel;

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        w3_valid = 1'b0; w3_a = '0; w3_b = '0; w3_rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready0", 64'(req0_ready), 64'd0);
        check("rst_ready1", 64'(req1_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
        check("rst_rsp_valid", 64'(rsp0_valid | rsp1_valid), 64'd0);
        check("rst_rsp0_p", rsp0_p, 64'd0);
        check("rst_rsp1_p", rsp1_p, 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        v = '{1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 64'd15, 0};
        tbl.push_back(v);
        v = '{1'b0, 1'b1, 32'd0, 32'd0, 32'd5, 32'd7, 1'b1, 64'd35, 0};
        tbl.push_back(v);
        for (int k = 0; k < 4; k++) begin
            v = '{1'b1, 1'b1, 32'd2, 32'd2, 32'd7, 32'd6, 1'b0, 64'd4, 0};
            if (k % 2 == 1 && !Fixed) begin
                v.port = 1'b1;
                v.p = 64'd42;
            end
            tbl.push_back(v);
        end
        v = '{1'b0, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1,
              64'hFFFF_FFFE_0000_0001, 5};
        tbl.push_back(v);
        v = '{1'b1, 1'b0, 32'd0, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 64'd0, 2};
        tbl.push_back(v);
        v = '{1'b0, 1'b1, 32'd0, 32'd0, 32'h8000_0000, 32'd2, 1'b1, 64'h1_0000_0000, 0};
        tbl.push_back(v);
        v = '{1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, 1'b0,
              64'h1_0000_0000, 1};
        tbl.push_back(v);
        foreach (tbl[i]) do_round(tbl[i]);

        // Reset while a job is in WAIT: the job is dropped without a response.
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("abort_busy_pre", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_mul_a", 64'(mul_a), 64'd0);
        check("abort_mul_b", 64'(mul_b), 64'd0);
        check("abort_rsp0_p", rsp0_p, 64'd0);
        check("abort_rsp1_p", rsp1_p, 64'd0);
        check("abort_valid", 64'(rsp0_valid | rsp1_valid | req0_ready | req1_ready), 64'd0);
        sb.delete();
        accepts = 0;
        resps = 0;
        @(posedge clk); @(posedge clk); #1;
        check("abort_no_rsp", 64'(rsp0_valid | rsp1_valid), 64'd0);
        rst_n = 1'b1;
        model_last = 1'b1;
        @(posedge clk); #1;
        v = '{1'b0, 1'b1, 32'd0, 32'd0, 32'd4, 32'd4, 1'b1, 64'd16, 0};
        do_round(v);

        // WAIT_CYC=3 instance: operands held three cycles, response on the fourth.
        w3_valid = 1'b1; w3_a = 32'd10; w3_b = 32'd10;
        #1;
        check("w3_ready", 64'(w3_ready), 64'd1);
        @(posedge clk); #1;
        w3_valid = 1'b0;
        n = 0;
        while (!w3_rsp_valid && n < 40) begin
            check("w3_mul_a", 64'(w3_mul_a), 64'd10);
            check("w3_mul_b", 64'(w3_mul_b), 64'd10);
            @(posedge clk); #1; n++;
        end
        check("w3_latency", 64'(n), 64'd3);
        check("w3_p", w3_rsp_p, 64'd100);
        w3_rsp_ready = 1'b1;
        @(posedge clk); #1;
        w3_rsp_ready = 1'b0;
        check("w3_busy", 64'(w3_busy), 64'd0);
        check("w3_idle1", 64'(w3_req1_ready | w3_rsp1_valid), 64'd0);
        check("w3_rsp1_p", w3_rsp1_p, 64'd0);

        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 2);
            v.v0 = (sel != 1);
            v.v1 = (sel != 0);
            v.a0 = $urandom; v.b0 = $urandom;
            v.a1 = $urandom; v.b1 = $urandom;
            v.port = (v.v0 && v.v1) ? (Fixed ? 1'b0 : !model_last) : v.v1;
            v.p = v.port ? 64'(v.a1) * 64'(v.b1) : 64'(v.a0) * 64'(v.b0);
            v.stall = $urandom_range(0, 2);
            do_round(v);
        end
        @(posedge clk); #1;
        check("sb_left", 64'(sb.size()), 64'd0);
        check("resp_count", 64'(resps), 64'(accepts));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Sequential scheduler that shares one combinational 32x32 `multiplier` instance between two requesters.
- Each requester uses a valid/ready operand channel and a valid/ready result channel.
- The block arbitrates round-robin, registers the operands that drive the shared multiplier, waits a configured number of cycles, captures the 64-bit product, and returns it to the owning requester.
- Sits between requester logic and the `multiplier` datapath; the multiplier itself stays outside this block.

Parameters:
- WAIT_CYC, 1, cycles the operands are held on mul_a/mul_b before mul_p is sampled; legal range 1..15, and 0 is illegal.

Ports:
- clk  in  1  system clock; all state on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has operands
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a  in  32  requester 0 multiplicand
- req0_b  in  32  requester 0 multiplier operand
- req1_valid  in  1  same as req0_valid, for requester 1
- req1_ready  out  1  same as req0_ready, for requester 1
- req1_a  in  32  same as req0_a, for requester 1
- req1_b  in  32  same as req0_b, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 takes result
- rsp0_p  out  64  product for requester 0
- rsp1_valid  out  1  same as rsp0_valid, for requester 1
- rsp1_ready  in  1  same as rsp0_ready, for requester 1
- rsp1_p  out  64  same as rsp0_p, for requester 1
- mul_a  out  32  operand A to the shared multiplier
- mul_b  out  32  operand B to the shared multiplier
- mul_p  in  64  product from the shared multiplier
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; mul_a=0; mul_b=0.
  - Result register=0; owner=0; counter=0.
  - rr_last=1, so requester 0 wins first.
  - All ready/valid outputs are 0; rsp0_p=rsp1_p=0.
- Reset asserted mid-operation aborts the job; no response is produced.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Grant is combinational. If only one reqN_valid is high, it wins.
  - If both are high, the requester other than rr_last wins.
  - reqN_ready=1 only for the winner, and only in IDLE.
  - On the handshake edge: mul_a/mul_b<=operands, owner<=N, counter<=WAIT_CYC-1, state<=WAIT.
  - If no valid is high, remain in IDLE; mul_a/mul_b hold their previous values and do not toggle.
- WAIT:
  - Both readys are 0.
  - If counter!=0, decrement.
  - If counter==0: result<=mul_p, state<=RESP.
  - Operands are therefore stable on mul_a/mul_b for exactly WAIT_CYC cycles.
- RESP:
  - rsp[owner]_valid=1 and rsp[owner]_p=result; the other rsp valid is 0.
  - Hold until rsp[owner]_ready=1. On that edge: rr_last<=owner, state<=IDLE.
  - No new request is accepted in the same cycle.
- rspN_p:
  - Shows the result register while rspN_valid=1.
  - Holds the last value otherwise, 0 after reset.
- Latency: handshake edge to rsp valid = WAIT_CYC+1 cycles. Throughput: one operation per WAIT_CYC+2 cycles minimum.
- Arithmetic: unsigned; the product is passed through unmodified. The block does no width extension or truncation.
- Requester rule: operands must be held stable while valid=1 and ready=0. Valid may be withdrawn before ready; arbitration is re-evaluated every cycle.
- Simultaneous requests: exactly one ready per cycle, never both.
- A requester holding rsp_ready low stalls the whole block. The other requester waits; this is intended.
- A response-ready asserted while rsp valid=0 is ignored.

Optional Feature:
- Macro MUL_ARB_FIXED_PRIO_EN.
- When defined: requester 0 always wins simultaneous requests; rr_last is not implemented.
- When undefined: round-robin as described in Behaviour.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset, then req0 a=3 b=5, WAIT_CYC=1:
  - req0_ready=1 in the first IDLE cycle.
  - mul_a=3, mul_b=5 for 1 cycle.
  - rsp0_valid=1 two cycles after the handshake, rsp0_p=15.
  - busy=0 after rsp0_ready.
- Both valid at once, repeated 4 times: req0 a=2 b=2, req1 a=7 b=6.
  - Round-robin grant order 0,1,0,1; products 4 and 42 on the correct rsp ports.
  - With MUL_ARB_FIXED_PRIO_EN: req1 is served only after req0_valid drops.
- req1 a=32'hFFFFFFFF b=32'hFFFFFFFF, rsp1_ready held low for 5 cycles:
  - rsp1_valid stays 1 with rsp1_p=64'hFFFFFFFE00000001.
  - req0_ready stays 0 throughout.
- WAIT_CYC=3, req0 a=10 b=10:
  - mul_a/mul_b stable for 3 cycles.
  - rsp0_valid appears 4 cycles after the handshake, rsp0_p=100.
- Assert rst_n=0 during WAIT:
  - All outputs 0 immediately.
  - After release, a new req1 a=4 b=4 is granted and returns 16.
- Random operands for 1000 jobs against a golden a*b:
  - No lost or duplicated responses.
  - Never both readys high, never both rsp valids high.
